// File: rtl/key_matrix_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_matrix_scanner_pkg
// Description : Shared matrix dimensions, event record and column-drive helper.
// Revision    : 1.0 - initial release
// ============================================================================
package key_matrix_scanner_pkg;

    localparam int NUM_COLS  = 4;
    localparam int NUM_ROWS  = 8;
    localparam int KEY_COUNT = NUM_COLS * NUM_ROWS;
    localparam int KEY_IDX_W = 5;
    localparam int COL_IDX_W = 2;
    localparam int ROW_IDX_W = 3;

    typedef struct packed {
        logic                 press;
        logic [KEY_IDX_W-1:0] code;
    } key_event_t;

    localparam int EVENT_W = $bits(key_event_t);

    // Active-low one-hot drive pattern for a column index.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_IDX_W-1:0] col);
        col_drive = ~(NUM_COLS'(1) << col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_matrix_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : key_matrix_scanner_if
// Description : Matrix drive/sense lines, key state and press/release event stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_matrix_scanner_if;
    import key_matrix_scanner_pkg::*;

    logic [NUM_COLS-1:0]  col_n;
    logic [NUM_ROWS-1:0]  row_n;
    logic [KEY_COUNT-1:0] keys;
    logic                 ev_valid;
    logic                 ev_ready;
    logic [KEY_IDX_W-1:0] ev_code;
    logic                 ev_press;
    logic                 overflow;
    logic                 ovf_clr;

    // master = scanner side, slave = matrix hardware plus event consumer
    modport master (
        output col_n, keys, ev_valid, ev_code, ev_press, overflow,
        input  row_n, ev_ready, ovf_clr
    );

    modport slave (
        input  col_n, keys, ev_valid, ev_code, ev_press, overflow,
        output row_n, ev_ready, ovf_clr
    );

endinterface
`default_nettype wire

// File: rtl/key_matrix_scanner_fifo.sv
`default_nettype none
// ============================================================================
// Module      : key_event_fifo
// Description : First-word-fall-through event queue; a push into a full queue
//               is accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] head_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   C_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             w_pop;
    logic             w_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == C_FULL);
    assign head_o  = mem_q[rd_ptr_q];
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // When full with a pop, the write slot is the one leaving the head.
            if (w_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!w_push && w_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : key_matrix_scanner
// Description : 4x8 key matrix strober with per-key debounce and event queue.
// Revision    : 1.0 - initial release
// ============================================================================
module key_matrix_scanner
    import key_matrix_scanner_pkg::*;
#(
    parameter int COL_CYCLES     = 3000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    key_matrix_scanner_if.master  bus
);

    localparam int               CNT_W        = $clog2(COL_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(COL_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_EVAL_START = CNT_W'(COL_CYCLES - NUM_ROWS);
    localparam logic [3:0]       C_DEB_LAST   = 4'(DEBOUNCE_SCANS - 1);

    logic [NUM_ROWS-1:0]  row_meta_q;
    logic [NUM_ROWS-1:0]  row_sync_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [COL_IDX_W-1:0] col_q, col_d;
    logic [NUM_COLS-1:0]  col_n_q, col_n_d;
    logic [KEY_COUNT-1:0] keys_q;
    logic [3:0]           deb_q [KEY_COUNT];
    logic                 ovf_q, ovf_d;

    logic                 w_wrap;
    logic                 w_eval;
    logic [CNT_W-1:0]     w_row_off;
    logic [ROW_IDX_W-1:0] w_row;
    logic [KEY_IDX_W-1:0] w_key;
    logic                 w_sample;
    logic                 w_disagree;
    logic                 w_flip;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    key_event_t           w_event;
    key_event_t           w_head;

    // The last NUM_ROWS cycles of each column period evaluate rows 0..7 in order.
    assign w_wrap     = (cnt_q == C_CNT_LAST);
    assign w_eval     = (cnt_q >= C_EVAL_START);
    assign w_row_off  = cnt_q - C_EVAL_START;
    assign w_row      = w_row_off[ROW_IDX_W-1:0];
    assign w_key      = {col_q, w_row};
    assign w_sample   = ~row_sync_q[w_row];
    assign w_disagree = (w_sample != keys_q[w_key]);
    assign w_flip     = w_eval & w_disagree & (deb_q[w_key] == C_DEB_LAST);

    assign w_event.press = w_sample;
    assign w_event.code  = w_key;

    assign w_pop  = ~w_empty & bus.ev_ready;
    assign w_drop = w_flip & w_full & ~w_pop;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        col_d   = col_q;
        col_n_d = col_n_q;
        if (w_wrap) begin
            cnt_d   = '0;
            col_d   = col_q + 1'b1;
            col_n_d = col_drive(col_d);
        end
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (w_drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            cnt_q      <= '0;
            col_q      <= '0;
            col_n_q    <= col_drive('0);
            keys_q     <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < KEY_COUNT; i++) begin
                deb_q[i] <= '0;
            end
        end else begin
            row_meta_q <= bus.row_n;
            row_sync_q <= row_meta_q;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            col_n_q    <= col_n_d;
            ovf_q      <= ovf_d;
            if (w_eval) begin
                if (!w_disagree) begin
                    deb_q[w_key] <= '0;
                end else if (w_flip) begin
                    deb_q[w_key]  <= '0;
                    keys_q[w_key] <= w_sample;
                end else begin
                    deb_q[w_key] <= deb_q[w_key] + 1'b1;
                end
            end
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_flip),
        .push_data_i (w_event),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .empty_o     (w_empty),
        .full_o      (w_full)
    );

    assign bus.col_n    = col_n_q;
    assign bus.keys     = keys_q;
    assign bus.ev_valid = ~w_empty;
    assign bus.ev_code  = w_head.code;
    assign bus.ev_press = w_head.press;
    assign bus.overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_key_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_matrix_scanner
// Description : Directed bench with a press model and an event scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_matrix_scanner;

    logic        clk;
    logic        reset;
    logic [31:0] pressed;
    logic [7:0]  row_n_w;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    int          cyc      = 0;
    int          pops_before;
    logic [5:0]  exp_q [$];
    logic [5:0]  exp_ev;

    key_matrix_scanner_if kif ();

    key_matrix_scanner #(
        .COL_CYCLES     (16),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A held key pulls its row low only while its column is driven.
    always_comb begin
        row_n_w = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[c*8+r] && !kif.col_n[c]) row_n_w[r] = 1'b0;
            end
        end
    end
    assign kif.row_n = row_n_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col_exp(input int c);
        logic [3:0] one;
        one = 4'b0001;
        col_exp = 4'b1111 ^ (one << c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && kif.ev_valid && kif.ev_ready) begin
            n_pops++;
            check("ev_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_ev = exp_q.pop_front();
                check("ev_head", {26'd0, kif.ev_press, kif.ev_code}, {26'd0, exp_ev});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        pressed     = '0;
        kif.ev_ready = 1'b0;
        kif.ovf_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_col_n", kif.col_n, 4'hE);
        check("rst_keys", kif.keys, 32'd0);
        check("rst_ev_valid", kif.ev_valid, 0);
        check("rst_ev_code", kif.ev_code, 0);
        check("rst_ev_press", kif.ev_press, 0);
        check("rst_overflow", kif.overflow, 0);
        reset = 1'b0;
        cyc   = 0;

        // Column sequencing over one frame plus wrap
        for (int i = 0; i <= 64; i++) begin
            check("col_seq", kif.col_n, col_exp((i / 16) % 4));
            if (i < 64) tick();
        end
        check("idle_keys", kif.keys, 32'd0);
        check("idle_ev_valid", kif.ev_valid, 0);

        // Debounced press and release of key 21 (c=2, r=5), F=64
        pressed[21] = 1'b1;
        wait_to(64 + 109);
        check("k21_before_flip", kif.keys[21], 0);
        tick();
        check("k21_press_keys", kif.keys[21], 1);
        check("k21_press_valid", kif.ev_valid, 1);
        check("k21_press_code", kif.ev_code, 21);
        check("k21_press_flag", kif.ev_press, 1);
        exp_q.push_back({1'b1, 5'd21});
        kif.ev_ready = 1'b1;
        tick();
        check("k21_popped", kif.ev_valid, 0);
        wait_to(64 + 192);
        pressed[21] = 1'b0;
        exp_q.push_back({1'b0, 5'd21});
        wait_to(64 + 320);
        check("k21_release_keys", kif.keys[21], 0);
        check("k21_release_seen", exp_q.size(), 0);
        check("k21_release_empty", kif.ev_valid, 0);

        // Bounce rejection on key 8 (c=1, r=0), twice, G=384
        pressed[8] = 1'b1;
        wait_to(384 + 64);
        pressed[8] = 1'b0;
        wait_to(384 + 128);
        pressed[8] = 1'b1;
        wait_to(384 + 192);
        pressed[8] = 1'b0;
        wait_to(384 + 256);
        check("bounce_keys", kif.keys, 32'd0);
        check("bounce_no_event", kif.ev_valid, 0);

        // Overflow with five simultaneous presses, H=640
        kif.ev_ready = 1'b0;
        pressed[4:0] = 5'h1F;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 5'(k)});
        wait_to(640 + 76);
        kif.ovf_clr = 1'b1;
        tick();
        kif.ovf_clr = 1'b0;
        check("ovf_drop_wins", kif.overflow, 1);
        check("ovf_keys", kif.keys[4:0], 5'h1F);
        wait_to(640 + 128);
        check("ovf_head_valid", kif.ev_valid, 1);
        check("ovf_head_code", kif.ev_code, 0);
        check("ovf_sticky", kif.overflow, 1);
        kif.ovf_clr = 1'b1;
        tick();
        kif.ovf_clr = 1'b0;
        check("ovf_cleared", kif.overflow, 0);
        pops_before  = n_pops;
        kif.ev_ready = 1'b1;
        repeat (4) tick();
        kif.ev_ready = 1'b0;
        check("ovf_drain_count", n_pops - pops_before, 4);
        check("ovf_drain_empty", kif.ev_valid, 0);
        check("ovf_drain_sb", exp_q.size(), 0);

        // Full queue with a pop in the pushing cycle, I=832
        wait_to(832);
        pressed[4:0] = 5'h00;
        for (int k = 0; k < 5; k++) exp_q.push_back({1'b0, 5'(k)});
        wait_to(832 + 76);
        check("full_valid", kif.ev_valid, 1);
        kif.ev_ready = 1'b1;
        tick();
        kif.ev_ready = 1'b0;
        check("full_pop_no_ovf", kif.overflow, 0);
        check("full_pop_keys", kif.keys[4:0], 5'h00);
        kif.ev_ready = 1'b1;
        repeat (4) tick();
        kif.ev_ready = 1'b0;
        check("full_drain_empty", kif.ev_valid, 0);
        check("full_drain_sb", exp_q.size(), 0);
        check("full_drain_ovf", kif.overflow, 0);

        // Async reset with two events queued and key 21 held, J=960
        wait_to(960);
        pressed = 32'h0020_0001;
        wait_to(960 + 128);
        check("pre_rst_keys", kif.keys, 32'h0020_0001);
        check("pre_rst_valid", kif.ev_valid, 1);
        check("pre_rst_code", kif.ev_code, 0);
        wait_to(960 + 150);
        check("pre_rst_col_n", kif.col_n, 4'hD);
        reset = 1'b1;
        #2;
        check("arst_col_n", kif.col_n, 4'hE);
        check("arst_keys", kif.keys, 32'd0);
        check("arst_valid", kif.ev_valid, 0);
        check("arst_overflow", kif.overflow, 0);
        pressed = 32'h0020_0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        exp_q.push_back({1'b1, 5'd21});
        wait_to(109);
        check("rearm_before", kif.keys[21], 0);
        tick();
        check("rearm_keys", kif.keys[21], 1);
        check("rearm_valid", kif.ev_valid, 1);
        check("rearm_code", kif.ev_code, 21);
        kif.ev_ready = 1'b1;
        tick();
        kif.ev_ready = 1'b0;
        check("rearm_sb", exp_q.size(), 0);
        check("rearm_empty", kif.ev_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
Input-side counterpart to the multiplexed 8x4 LED display. It strobes the four column lines in turn, samples eight row lines, and debounces each of the 32 keys. It outputs the debounced key state plus a queued press/release event stream with a valid/ready handshake, for the hex8 CPU or top-level glue to consume.

Parameters:
COL_CYCLES, 3000, clock cycles per column period (4 kHz column rate at 12 MHz); must be >= 16
DEBOUNCE_SCANS, 4, consecutive full-frame samples that must disagree with the stable state before a key flips; range 1..15
FIFO_DEPTH, 4, event queue depth; power of two

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
col_n  out  4  column drive, active-low one-hot
row_n  in  8  row sense, active-low (pulled up externally), asynchronous
keys  out  32  debounced state, 1 = pressed; index = col*8 + row
ev_valid  out  1  event available at queue head
ev_ready  in  1  consumer accepts head event when ev_valid & ev_ready
ev_code  out  5  key index of head event
ev_press  out  1  1 = press, 0 = release
overflow  out  1  sticky: an event was dropped because the queue was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (async, active-high) values: col_n=4'b1110, column index 0, cycle counter 0, keys=0, all debounce counters 0, queue empty, ev_valid=0, ev_code=0, ev_press=0, overflow=0. Synchroniser flops reset to 8'hFF.
- row_n passes through a 2-flop synchroniser before any use.
- Column period: the cycle counter runs 0..COL_CYCLES-1.
  - On wrap, the column index advances 0->1->2->3->0 and col_n updates the same cycle.
  - col_n is registered and changes only on wrap.
- Row evaluation: at counter values COL_CYCLES-8+r (r=0..7), evaluate exactly one key, k = col*8 + r. At most one key is evaluated per cycle.
- Per-key debounce, with s = synchronised sample inverted (1 = pressed):
  - s == keys[k]: counter[k] <= 0.
  - s != keys[k] and counter[k]+1 < DEBOUNCE_SCANS: counter[k] increments.
  - s != keys[k] and counter[k]+1 == DEBOUNCE_SCANS: keys[k] flips, counter[k] <= 0, push event {code=k, press=new keys[k]}.
  - With DEBOUNCE_SCANS=1, a key flips on the first disagreeing sample.
- Event latency: the event is visible at the queue head (ev_valid high) the cycle after the flip if the queue was empty. keys updates in the same cycle as the push.
- Queue: FIFO, first-word-fall-through; ev_code/ev_press are valid whenever ev_valid=1.
  - Pop on ev_valid & ev_ready.
  - Push accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow <= 1. keys still updates, so the key state is never lost.
  - Push and pop on an empty queue: no bypass; the head appears the next cycle.
- overflow: ovf_clr clears it. If a drop and ovf_clr occur in the same cycle, the drop wins and overflow stays 1.
- ev_ready while ev_valid=0: ignored.
- Frame = 4*COL_CYCLES cycles; each key is sampled once per frame.

Decomposition:
- Shared package constants: NUM_COLS=4, NUM_ROWS=8, KEY_COUNT=32, KEY_IDX_W=5. The LED display uses the same dimensions.
- One sub-module: key_event_fifo (parameterised depth/width, FWFT, full/empty, push/pop). Instantiate it with width 6 = {press, code}.
- Debounce counters and scan sequencing stay in the top module.

Test Plan (COL_CYCLES=16, DEBOUNCE_SCANS=2, FIFO_DEPTH=4; press model drives row_n[r]=0 only while col_n[c]=0):
- Column sequencing: release reset -> col_n=1110 for 16 cycles, then 1101, 1011, 0111, then back to 1110 at cycle 64. No events; keys=0.
- Debounced press/release: hold key c=2,r=5 for 3 frames -> after the 2nd frame's evaluation keys[21]=1, ev_valid=1, ev_code=21, ev_press=1. Pop with ev_ready=1. Release for 2 frames -> keys[21]=0, event {21, press=0}.
- Bounce rejection: hold key c=1,r=0 for exactly 1 frame, then release -> keys[8] stays 0, no event, counter returns to 0.
- Overflow: ev_ready=0; press keys 0..4 (column 0, rows 0..4) together -> keys[4:0]=5'h1F, queue holds codes 0,1,2,3 in order, overflow=1. Pulse ovf_clr -> overflow=0. Drain -> exactly 4 events.
- Full with simultaneous pop: queue full, ev_ready=1 in the cycle a new event pushes -> event accepted, overflow stays 0, order preserved.
- Async reset mid-operation: assert reset with 2 events queued and key 21 pressed -> col_n=1110, keys=0, ev_valid=0, overflow=0 immediately, without waiting for a clock edge. After release, a held key re-reports as a press after 2 frames.
